// File: rtl/mips_pkg.sv
// Shared definitions for the mips32 ID-stage branch logic:
// branch codes, PC-select encodings and the branch controller state type.
package mips_pkg;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JMP  = 2'b11;

   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_J   = 2'b10;
   localparam logic [1:0] PC_SEL_JR  = 2'b11;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch comparator: decides whether the branch/jump in ID is taken.
// Purely combinational; operands arrive already forwarded.
module branch_cmp
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        code,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              taken
);

   logic equal;

   assign equal = (rs_data == rt_data);

   assign taken = ((code == BR_BEQ) &&  equal) ||
                  ((code == BR_BNE) && !equal) ||
                   (code == BR_JMP);

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the mips32 ID stage: hazard-driven
// front-end stall, branch resolve, PC select/target, IF/ID flush, counters.
module branch_ctrl
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        code,
   input  logic              is_jr,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] br_target,
   input  logic [DATA_W-1:0] j_target,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [4:0]        ex_rd,
   input  logic              mem_mem_read,
   input  logic [4:0]        mem_rd,
   input  logic              kill,
   output logic              stall,
   output logic              flush_if,
   output logic [1:0]        pc_sel,
   output logic [DATA_W-1:0] pc_target,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   br_state_e  state_q, state_d;
   logic [1:0] wait_q, wait_d;
   logic       taken;
   logic       take;
   logic       use_rs, use_rt;
   logic [1:0] depth_rs, depth_rt, depth;

   // Cycles until a source register can be forwarded to ID.
   function automatic logic [1:0] src_depth(
      input logic [4:0] src,
      input logic [4:0] e_rd,
      input logic       e_write,
      input logic       e_load,
      input logic [4:0] m_rd,
      input logic       m_load
   );
      logic [1:0] d;
      d = 2'd0;
      if (src != 5'd0) begin
         if (src == e_rd && e_load)
            d = 2'd2;
         else if (src == e_rd && e_write)
            d = 2'd1;
         else if (src == m_rd && m_load)
            d = 2'd1;
      end
      return d;
   endfunction

   assign use_rt = (code == BR_BEQ) || (code == BR_BNE);
   assign use_rs = use_rt || ((code == BR_JMP) && is_jr);

   assign depth_rs = use_rs ? src_depth(rs_addr, ex_rd, ex_reg_write, ex_mem_read,
                                        mem_rd, mem_mem_read) : 2'd0;
   assign depth_rt = use_rt ? src_depth(rt_addr, ex_rd, ex_reg_write, ex_mem_read,
                                        mem_rd, mem_mem_read) : 2'd0;
   assign depth    = (depth_rs > depth_rt) ? depth_rs : depth_rt;

   branch_cmp #(.DATA_W(DATA_W)) u_cmp (
      .code    (code),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .taken   (taken)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      wait_d   = wait_q;
      stall    = 1'b0;
      flush_if = 1'b0;
      pc_sel   = PC_SEL_SEQ;
      take     = 1'b0;
      // Outputs are quiet while reset is held, even though they are combinational.
      if (!rst_n || kill) begin
         state_d = ST_RUN;
         wait_d  = 2'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (depth != 2'd0) begin
                  stall   = 1'b1;
                  wait_d  = depth - 2'd1;
                  state_d = (depth == 2'd1) ? ST_RUN : ST_STALL;
               end else if (taken) begin
                  flush_if = 1'b1;
                  take     = 1'b1;
                  if (code == BR_JMP)
                     pc_sel = is_jr ? PC_SEL_JR : PC_SEL_J;
                  else
                     pc_sel = PC_SEL_BR;
               end
            end
            ST_STALL: begin
               stall = 1'b1;
               if (wait_q <= 2'd1) begin
                  wait_d  = 2'd0;
                  state_d = ST_RUN;
               end else begin
                  wait_d = wait_q - 2'd1;
               end
            end
            default: begin
               state_d = ST_RUN;
               wait_d  = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      case (pc_sel)
         PC_SEL_BR: pc_target = br_target;
         PC_SEL_J:  pc_target = j_target;
         PC_SEL_JR: pc_target = rs_data;
         default:   pc_target = '0;
      endcase
   end

   // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         wait_q    <= 2'd0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (take)
            taken_cnt <= taken_cnt + 1'b1;
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
